serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: computes a WIDTH-bit sum by sequencing one FullAdder cell over WIDTH clock cycles, LSB first.
- Holds operands in shift registers and keeps the carry in a flip-flop between bits.
- Start/done handshake; sits between a register file or host and the single shared FullAdder datapath cell.
- First sequential block built on the gate-level adder cell.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, high in DONE
- sum  output  WIDTH  result; valid from done, held until next accepted start
- cout  output  1  final carry; same validity as sum

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; shift registers, carry flip-flop and bit counter all cleared.
- States:
  - IDLE: start=1 -> load A_sr=a, B_sr=b, carry=cin, cnt=0, S_sr=0, and enter RUN.
  - RUN: each edge feeds A_sr[0], B_sr[0] and carry into FullAdder. The sum bit shifts into S_sr from the MSB side. carry<=cout_fa. A_sr and B_sr shift right. cnt<=cnt+1. When cnt==WIDTH-1 on that edge, enter DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start sampled at edge k. Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH. done=1 during the cycle after edge k+WIDTH. Each operation takes WIDTH+2 cycles from start accept until the block is back in IDLE.
- Counter width: $clog2(WIDTH+1) bits.
- sum and cout drive straight from S_sr and the carry flip-flop. They are not updated in IDLE or DONE, so the value holds after done.
- start while busy or in DONE: ignored, no queueing. Operands are sampled only on the accepting edge; changes to a, b or cin afterwards have no effect.
- Back-to-back: start held high continuously launches a new operation on the first IDLE cycle after DONE.
- reset mid-RUN or in DONE: abort immediately to reset values; no done pulse.
- WIDTH=1: a single RUN cycle, then DONE.

Optional Feature:
- Macro: SERIAL_ADDER_CTRL_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with start.
  - sub=1: load B_sr=~b and carry=1; cin is ignored. Result is a-b mod 2^WIDTH, and cout=1 means no borrow (a>=b).
  - sub=0: normal add.
- Undefined: no sub port; add only.

Decomposition:
- Shared header serial_adder_defs.vh: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and default WIDTH constant.
- One sub-module: the existing FullAdder, instantiated once as the datapath cell.
- Shift registers, counter and FSM stay in serial_adder_ctrl.

Test Plan:
- Reset held 2 cycles -> busy=0, done=0, sum=8'h00, cout=0 while in reset and after release.
- a=8'h3C, b=8'h05, cin=0, start pulse -> busy for 8 cycles; done pulse in cycle 9 after accept; sum=8'h41, cout=0; values held 5 cycles later.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start pulsed at RUN cycle 3 with different operands -> ignored; result matches the first operands; exactly one done pulse.
- reset asserted at RUN cycle 4, then fresh start with a=8'h10, b=8'h20 -> no done from the aborted op; sum=8'h30, cout=0.
- With SERIAL_ADDER_CTRL_SUB_EN: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0. Then sub=1, a=8'h07, b=8'h05 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl_pkg
//  Description : Shared definitions for the bit-serial adder controller.
//                Holds the FSM state encodings and the default operand width.
//                The optional subtract mode is selected by the macro
//                SERIAL_ADDER_CTRL_SUB_EN, which is handled in the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_ctrl_pkg;

    // Operand/result width used when the instantiating code does not override it
    localparam int c_default_width = 8;

    // Controller state encodings
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

endpackage : serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_fa.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl_fa
//  Description : Single-bit full adder cell. This is the one shared datapath
//                cell that the serial controller steps over every operand bit.
//  Ports       : a, b, ci  - operand bits and carry in
//                s, co     - sum bit and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : serial_adder_ctrl_fa
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder controller. Computes a WIDTH-bit sum by
//                sequencing one full adder cell over WIDTH cycles, LSB first.
//                Operands live in shift registers and the carry in a flop.
//                Optional macro SERIAL_ADDER_CTRL_SUB_EN adds a 'sub' input
//                that turns the operation into a - b (two's complement).
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start               - request, honoured only in IDLE
//                a, b, cin           - operands, captured on accepted start
//                sub                 - (macro only) subtract select
//                busy, done          - RUN indicator, one-cycle done pulse
//                sum, cout           - result and final carry
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic [WIDTH-1:0] w_s_shift;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fa_s;
    logic             w_fa_co;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // ------------------------------------------------------------------------
    // Load values for the B register and carry. Subtraction is a + ~b + 1.
    // ------------------------------------------------------------------------
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    assign w_b_load = sub ? ~b   : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    // ------------------------------------------------------------------------
    // Shared datapath cell
    // ------------------------------------------------------------------------
    serial_adder_ctrl_fa u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // New sum bit enters from the MSB so that after WIDTH shifts bit 0 of the
    // result lands in position 0.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_s_shift = w_fa_s;
        end else begin : g_shift_wn
            assign w_s_shift = {w_fa_s, r_s_sr[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start)                w_state_next = c_st_run;
            c_st_run:  if (r_cnt == c_cnt_last)  w_state_next = c_st_done;
            c_st_done:                           w_state_next = c_st_idle;
            default:                             w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand/result shift registers, carry flop, bit counter.
    // Nothing changes in DONE, so the result holds until the next accept.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= w_b_load;
                        r_s_sr  <= '0;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                    end
                end
                c_st_run: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_s_sr  <= w_s_shift;
                    r_carry <= w_fa_co;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == c_st_run);
    assign done = (r_state == c_st_done);
    assign sum  = r_s_sr;
    assign cout = r_carry;

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
//                Define SERIAL_ADDER_CTRL_SUB_EN to also exercise subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int r_checks = 0;
    int r_errors = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_CTRL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands and a one-cycle start; returns at the negedge after
    // the accepting rising edge (cycle 1 after accept).
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done, returning the cycle number (after accept) it was seen
    // and how many cycles busy was high on the way. Bounded.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 30) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 32'(lat), 32'd9);
    endtask

    int lat;
    int bcnt;
    int dcnt;

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // ---------------- reset ----------------
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'h00);
        check("rst_cout", 32'(cout), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sum",  32'(sum),  32'h00);

        // ---------------- basic add + latency ----------------
        launch(8'h3C, 8'h05, 1'b0, 1'b0);
        a = 8'hFF; b = 8'hFF; cin = 1'b1;       // post-accept changes must be ignored
        wait_done(lat, bcnt);
        check("add1_latency", 32'(lat),  32'd9);
        check("add1_busycyc", 32'(bcnt), 32'd8);
        check("add1_busy_in_done", 32'(busy), 32'd0);
        check("add1_sum",  32'(sum),  32'h41);
        check("add1_cout", 32'(cout), 32'd0);
        @(negedge clk);
        check("add1_done_pulse", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        check("add1_hold_sum",  32'(sum),  32'h41);
        check("add1_hold_cout", 32'(cout), 32'd0);

        // ---------------- carry chain ----------------
        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bcnt);
        check("carry1_sum",  32'(sum),  32'h00);
        check("carry1_cout", 32'(cout), 32'd1);
        launch(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done(lat, bcnt);
        check("carry2_sum",  32'(sum),  32'hFF);
        check("carry2_cout", 32'(cout), 32'd1);

        // ---------------- start during RUN is ignored ----------------
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);                          // RUN cycle 3
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                dcnt++;
                check("ign_sum",  32'(sum),  32'h46);
                check("ign_cout", 32'(cout), 32'd0);
            end
            @(negedge clk);
        end
        check("ign_done_count", 32'(dcnt), 32'd1);

        // ---------------- reset mid-RUN ----------------
        launch(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);               // RUN cycle 4
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum",  32'(sum),  32'h00);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done(lat, bcnt);
        check("fresh_sum",  32'(sum),  32'h30);
        check("fresh_cout", 32'(cout), 32'd0);

        // ---------------- back-to-back with start held ----------------
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(lat, bcnt);
        check("b2b_first_sum", 32'(sum), 32'h03);
        a = 8'h40; b = 8'h04;
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_relaunch_busy", 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        check("b2b_second_sum", 32'(sum), 32'h44);

`ifdef SERIAL_ADDER_CTRL_SUB_EN
        // ---------------- subtraction ----------------
        launch(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        check("sub1_sum",  32'(sum),  32'hFE);
        check("sub1_cout", 32'(cout), 32'd0);
        launch(8'h07, 8'h05, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        check("sub2_sum",  32'(sum),  32'h02);
        check("sub2_cout", 32'(cout), 32'd1);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
